// File: rtl/sc_stream_decoder.sv
// Stochastic-bitstream decoder: counts the ones in each WIN-bit window.
// Optional macro SC_DEC_ERR_EN drives abs_err with |result - latched ref_val|.
module sc_stream_decoder #(
    parameter int unsigned WIN = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       bit_in,
    input  logic [7:0] ref_val,
    output logic       busy,
    output logic [7:0] result,
    output logic       valid,
    output logic [7:0] abs_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [7:0] LastIdx = 8'(WIN - 1);

    state_e     r_state;
    logic [7:0] r_ones;
    logic [7:0] r_idx;
    logic [7:0] r_result;
    logic       r_busy;
    logic       r_valid;

    logic [7:0] w_count;
    logic       w_enter_run;
    logic       w_finish;

    // Count including this cycle's bit; loaded into result on the last index.
    assign w_count     = r_ones + {7'd0, bit_in};
    assign w_enter_run = ((r_state == StIdle) && start) ||
                         ((r_state == StDone) && (start || cont));
    assign w_finish    = (r_state == StRun) && (r_idx == LastIdx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_ones   <= 8'd0;
            r_idx    <= 8'd0;
            r_result <= 8'd0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    r_valid <= 1'b0;
                    if (w_enter_run) begin
                        r_state <= StRun;
                        r_busy  <= 1'b1;
                        r_ones  <= 8'd0;
                        r_idx   <= 8'd0;
                    end else begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                end
                StRun: begin
                    // start is deliberately not looked at here
                    r_ones <= w_count;
                    r_idx  <= r_idx + 8'd1;
                    if (w_finish) begin
                        r_state  <= StDone;
                        r_result <= w_count;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign result = r_result;

`ifdef SC_DEC_ERR_EN
    logic [7:0] r_ref;
    logic [7:0] r_abs_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ref     <= 8'd0;
            r_abs_err <= 8'd0;
        end else begin
            if (w_enter_run) begin
                r_ref <= ref_val;
            end
            if (w_finish) begin
                r_abs_err <= (w_count >= r_ref) ? (w_count - r_ref) : (r_ref - w_count);
            end
        end
    end

    assign abs_err = r_abs_err;
`else
    logic w_unused_ref;

    assign w_unused_ref = ^ref_val;
    assign abs_err      = 8'd0;
`endif

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomized self-checking bench for sc_stream_decoder (WIN=255 and WIN=1 instances).
module tb_sc_stream_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic       cont;
    logic       bit_in;
    logic [7:0] ref_val;
    logic       busy, valid, busy1, valid1;
    logic [7:0] result, abs_err, result1, abs_err1;

    int n_checks = 0;
    int n_errors = 0;
    bit stim[255];

    always #5 clk = ~clk;

    sc_stream_decoder #(.WIN(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .bit_in(bit_in),
        .ref_val(ref_val), .busy(busy), .result(result), .valid(valid), .abs_err(abs_err)
    );

    sc_stream_decoder #(.WIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont), .bit_in(bit_in),
        .ref_val(ref_val), .busy(busy1), .result(result1), .valid(valid1),
        .abs_err(abs_err1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_err(input int r, input int rf);
`ifdef SC_DEC_ERR_EN
        return (r > rf) ? r - rf : rf - r;
`else
        return 0;
`endif
    endfunction

    task automatic fill_const(input bit b);
        for (int i = 0; i < 255; i++) stim[i] = b;
    endtask

    task automatic fill_alt();
        for (int i = 0; i < 255; i++) stim[i] = (i % 2 == 0);
    endtask

    task automatic fill_rand(input int pct);
        for (int i = 0; i < 255; i++) stim[i] = ($urandom_range(99) < pct);
    endtask

    // Exactly k ones, scattered by random swaps.
    task automatic fill_exact(input int k);
        for (int i = 0; i < 255; i++) stim[i] = (i < k);
        for (int i = 0; i < 255; i++) begin
            int j;
            bit t;
            j       = $urandom_range(254);
            t       = stim[i];
            stim[i] = stim[j];
            stim[j] = t;
        end
    endtask

    // One window: start in cycle t, bits in t+1..t+255, valid expected in t+256.
    task automatic run_window(input string tag, input logic [7:0] refv, input int pulse_at);
        int ones = 0;
        int bad  = 0;
        start   = 1'b1;
        cont    = 1'b0;
        ref_val = refv;
        bit_in  = 1'($urandom);
        step();
        for (int i = 0; i < 255; i++) begin
            ref_val = 8'($urandom);
            bit_in  = stim[i];
            start   = (i == pulse_at);
            ones   += int'(stim[i]);
            if (busy !== 1'b1 || valid !== 1'b0) bad++;
            step();
        end
        start  = 1'b0;
        bit_in = 1'($urandom);
        check_eq({tag, " run busy/valid"}, bad, 0);
        check_eq({tag, " valid"}, int'(valid === 1'b1), 1);
        check_eq({tag, " result"}, int'(result), ones);
        check_eq({tag, " abs_err"}, int'(abs_err), exp_err(ones, int'(refv)));
        check_eq({tag, " busy in done"}, int'(busy === 1'b1), 0);
        step();
        check_eq({tag, " valid drop"}, int'(valid === 1'b1), 0);
        check_eq({tag, " result hold"}, int'(result), ones);
    endtask

    initial begin
        int t, last, npulse, gap_bad, res_bad, hits;
        rst_n   = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        cont    = 1'b0;
        bit_in  = 1'b0;
        ref_val = 8'hAA;
        step();
        step();
        check_eq("rst busy", int'(busy === 1'b1), 0);
        check_eq("rst valid", int'(valid === 1'b1), 0);
        check_eq("rst result", int'(result), 0);
        check_eq("rst abs_err", int'(abs_err), 0);
        check_eq("rst result1", int'(result1), 0);

        // Start in the very first cycle after reset release.
        rst_n = 1'b1;
        fill_const(1'b1);
        run_window("ones", 8'd200, -1);
        fill_const(1'b0);
        run_window("zeros", 8'd3, -1);
        fill_alt();
        run_window("alt", 8'd128, -1);
        fill_exact(90);
        run_window("err90", 8'd100, -1);
        fill_rand(50);
        run_window("restart", 8'($urandom), 100);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(3)) step();
            fill_rand($urandom_range(100));
            run_window("rand", 8'($urandom), -1);
        end

        // Continuous mode: three back-to-back windows of ones.
        cont   = 1'b1;
        start  = 1'b1;
        bit_in = 1'b1;
        step();
        start   = 1'b0;
        t       = 1;
        last    = 0;
        npulse  = 0;
        gap_bad = 0;
        res_bad = 0;
        while (npulse < 3 && t < 1000) begin
            if (valid === 1'b1) begin
                if (t - last != 256) gap_bad++;
                if (result != 8'd255) res_bad++;
                last = t;
                npulse++;
                if (npulse == 3) cont = 1'b0;
                bit_in = 1'($urandom);
            end else begin
                bit_in = 1'b1;
            end
            step();
            t++;
        end
        check_eq("cont pulses", npulse, 3);
        check_eq("cont spacing", gap_bad, 0);
        check_eq("cont result", res_bad, 0);
        check_eq("cont stop busy", int'(busy === 1'b1), 0);

        // Reset at index 100 of a window.
        start  = 1'b1;
        bit_in = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("midrst result", int'(result), 0);
        check_eq("midrst abs_err", int'(abs_err), 0);
        check_eq("midrst busy", int'(busy === 1'b1), 0);
        hits = 0;
        for (int i = 0; i < 300; i++) begin
            if (valid === 1'b1 || busy === 1'b1) hits++;
            step();
        end
        check_eq("midrst no pulse", hits, 0);
        check_eq("midrst result hold", int'(result), 0);

        // WIN=1 boundary.
        start1  = 1'b1;
        ref_val = 8'd7;
        bit_in  = 1'b0;
        step();
        start1 = 1'b0;
        bit_in = 1'b1;
        check_eq("win1 busy", int'(busy1 === 1'b1), 1);
        check_eq("win1 early valid", int'(valid1 === 1'b1), 0);
        step();
        bit_in = 1'b0;
        check_eq("win1 valid", int'(valid1 === 1'b1), 1);
        check_eq("win1 result", int'(result1), 1);
        check_eq("win1 abs_err", int'(abs_err1), exp_err(1, 7));
        step();
        check_eq("win1 valid drop", int'(valid1 === 1'b1), 0);
        start1 = 1'b1;
        bit_in = 1'b1;
        step();
        start1 = 1'b0;
        bit_in = 1'b0;
        step();
        check_eq("win1 zero", int'(result1), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
